request_encoder: RTL and testbench

REQUEST_ENCODER -- requirements
Module: request_encoder

---
 rtl/atc_pkg.sv | 13 +
 rtl/rr_search.sv | 29 ++
 rtl/request_encoder.sv | 107 ++++++++++
 tb/tb_request_encoder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/atc_pkg.sv
// Shared request-code constants and encoder FSM state encoding.
// Also used by the 4-to-16 decoder side, so the encoding is kept fixed here.
package atc_pkg;

  localparam int N_REQ  = 16;
  localparam int CODE_W = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_search.sv
// Round-robin search: finds the first set pending bit at ptr, ptr+1, ... with wrap.
// Purely combinational; there is no latency and no flow control.
module rr_search #(
  parameter int N_REQ  = atc_pkg::N_REQ,
  parameter int CODE_W = atc_pkg::CODE_W
) (
  input  logic [N_REQ-1:0]  pending,
  input  logic [CODE_W-1:0] ptr,
  output logic              found,
  output logic [CODE_W-1:0] idx
);

  logic [CODE_W-1:0] cand;

  // N_REQ == 2**CODE_W, so the CODE_W-bit add performs the wrap for free.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + CODE_W'(i);
      if (!found && pending[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/request_encoder.sv
// Round-robin encoder of pending request lines into a registered code/valid offer.
// Latency is two edges from req to valid; code holds under backpressure, with one idle cycle after each accept.
module request_encoder #(
  parameter int N_REQ  = atc_pkg::N_REQ,
  parameter int CODE_W = atc_pkg::CODE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic              flush,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ready,
  output logic [CODE_W:0]   pending_cnt
);

  import atc_pkg::*;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [N_REQ-1:0]  clr_mask;
  logic              accept;
  logic              found;
  logic [CODE_W-1:0] found_idx;
  logic [CODE_W:0]   cnt;

  rr_search #(
    .N_REQ  (N_REQ),
    .CODE_W (CODE_W)
  ) u_search (
    .pending (pending_q),
    .ptr     (ptr_q),
    .found   (found),
    .idx     (found_idx)
  );

  assign accept = (state_q == PRESENT) && ready;

  always_comb begin
    clr_mask = '0;
    if (accept) begin
      clr_mask[code_q] = 1'b1;
    end
  end

  // A req on the granted slot in the accept cycle wins over its clear.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    ptr_d     = ptr_q;
    pending_d = (pending_q & ~clr_mask) | req;
    if (flush) begin
      state_d   = IDLE;
      code_d    = '0;
      ptr_d     = '0;
      pending_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_d = PRESENT;
            code_d  = found_idx;
          end
        end
        PRESENT: begin
          if (ready) begin
            state_d = IDLE;
            code_d  = '0;
            ptr_d   = code_q + CODE_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          code_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      code_q    <= '0;
      ptr_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cnt = cnt + (CODE_W+1)'(pending_q[i]);
    end
  end

  assign pending_cnt = cnt;
  assign valid       = (state_q == PRESENT);
  assign code        = code_q;

endmodule

// File: tb/tb_request_encoder.sv
// Bench for request_encoder: directed vector table, async-reset sequences, and random traffic vs a reference model.
module tb_request_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        flush;
  logic        ready;
  logic        valid;
  logic [3:0]  code;
  logic [4:0]  pending_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  request_encoder #(
    .N_REQ  (16),
    .CODE_W (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .flush       (flush),
    .code        (code),
    .valid       (valid),
    .ready       (ready),
    .pending_cnt (pending_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] req;
    logic        rdy;
    logic        fl;
    logic        v;
    logic [3:0]  c;
    logic [4:0]  n;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [15:0] r, input logic rd, input logic fl,
                     input logic v, input logic [3:0] c, input logic [4:0] n);
    vec_t e;
    e.req = r;
    e.rdy = rd;
    e.fl  = fl;
    e.v   = v;
    e.c   = c;
    e.n   = n;
    tbl.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: pending set as a bit array, presented grant and pointer as integers.
  bit m_pend[16];
  bit m_pres;
  int m_code;
  int m_ptr;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
    m_pres = 1'b0;
    m_code = 0;
    m_ptr  = 0;
  endtask

  task automatic model_step(input logic [15:0] r, input logic rd, input logic fl);
    bit old[16];
    bit acc;
    int acc_idx;
    for (int i = 0; i < 16; i++) old[i] = m_pend[i];
    acc     = m_pres && rd;
    acc_idx = m_code;
    if (fl) begin
      model_reset();
    end else begin
      if (m_pres) begin
        if (rd) begin
          m_ptr  = (m_code + 1) % 16;
          m_pres = 1'b0;
          m_code = 0;
        end
      end else begin
        for (int k = 0; k < 16; k++) begin
          if (old[(m_ptr + k) % 16]) begin
            m_code = (m_ptr + k) % 16;
            m_pres = 1'b1;
            break;
          end
        end
      end
      for (int i = 0; i < 16; i++) begin
        m_pend[i] = (old[i] && !(acc && i == acc_idx)) || r[i];
      end
    end
  endtask

  function automatic int model_cnt();
    int s = 0;
    for (int i = 0; i < 16; i++) s += int'(m_pend[i]);
    return s;
  endfunction

  initial begin
    // Cycle-by-cycle vectors: inputs for the next edge, outputs expected after it.
    // Single request at slot 5, then pointer-at-6 probe with slots 0 and 6.
    add(16'h0020, 1'b1, 1'b0, 1'b0, 4'd0,  5'd1);
    add(16'h0000, 1'b1, 1'b0, 1'b1, 4'd5,  5'd1);
    add(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  5'd0);
    add(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  5'd0);
    add(16'h0041, 1'b0, 1'b0, 1'b0, 4'd0,  5'd2);
    add(16'h0000, 1'b0, 1'b0, 1'b1, 4'd6,  5'd2);
    add(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  5'd1);
    add(16'h0000, 1'b1, 1'b0, 1'b1, 4'd0,  5'd1);
    add(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  5'd0);
    add(16'h0000, 1'b1, 1'b1, 1'b0, 4'd0,  5'd0);
    // Round robin over slots 0 and 15, twice, checking wrap of the pointer.
    add(16'h8001, 1'b1, 1'b0, 1'b0, 4'd0,  5'd2);
    add(16'h0000, 1'b1, 1'b0, 1'b1, 4'd0,  5'd2);
    add(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  5'd1);
    add(16'h0000, 1'b1, 1'b0, 1'b1, 4'd15, 5'd1);
    add(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  5'd0);
    add(16'h8001, 1'b1, 1'b0, 1'b0, 4'd0,  5'd2);
    add(16'h0000, 1'b1, 1'b0, 1'b1, 4'd0,  5'd2);
    add(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  5'd1);
    add(16'h0000, 1'b1, 1'b0, 1'b1, 4'd15, 5'd1);
    add(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  5'd0);
    // Backpressure: code 2 held for five ready-low cycles, then 8.
    add(16'h0104, 1'b0, 1'b0, 1'b0, 4'd0,  5'd2);
    for (int i = 0; i < 5; i++) add(16'h0000, 1'b0, 1'b0, 1'b1, 4'd2, 5'd2);
    add(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  5'd1);
    add(16'h0000, 1'b1, 1'b0, 1'b1, 4'd8,  5'd1);
    add(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  5'd0);
    // Set wins over clear on the accepted slot; slot 3 is served again.
    add(16'h0008, 1'b0, 1'b0, 1'b0, 4'd0,  5'd1);
    add(16'h0000, 1'b0, 1'b0, 1'b1, 4'd3,  5'd1);
    add(16'h0008, 1'b1, 1'b0, 1'b0, 4'd0,  5'd1);
    add(16'h0000, 1'b1, 1'b0, 1'b1, 4'd3,  5'd1);
    add(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  5'd0);
    // Move pointer to 7, fill all slots, flush while presenting 7.
    add(16'h0040, 1'b1, 1'b0, 1'b0, 4'd0,  5'd1);
    add(16'h0000, 1'b1, 1'b0, 1'b1, 4'd6,  5'd1);
    add(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  5'd0);
    add(16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd0,  5'd16);
    add(16'h0000, 1'b0, 1'b0, 1'b1, 4'd7,  5'd16);
    add(16'h0001, 1'b0, 1'b1, 1'b0, 4'd0,  5'd0);
    add(16'h0000, 1'b0, 1'b0, 1'b0, 4'd0,  5'd0);
    add(16'h0000, 1'b0, 1'b0, 1'b0, 4'd0,  5'd0);
    // Flush also returned the pointer to 0: slot 1 before slot 15.
    add(16'h8002, 1'b0, 1'b0, 1'b0, 4'd0,  5'd2);
    add(16'h0000, 1'b0, 1'b0, 1'b1, 4'd1,  5'd2);
    add(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  5'd1);
    add(16'h0000, 1'b1, 1'b0, 1'b1, 4'd15, 5'd1);
    add(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  5'd0);

    // Reset held with every request line high.
    rst_n = 1'b0;
    req   = 16'hFFFF;
    flush = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst.valid", int'(valid), 0);
      check("rst.code",  int'(code), 0);
      check("rst.cnt",   int'(pending_cnt), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rel1.valid", int'(valid), 0);
    check("rel1.cnt",   int'(pending_cnt), 16);
    @(negedge clk);
    check("rel2.valid", int'(valid), 1);
    check("rel2.code",  int'(code), 0);
    req   = 16'h0000;
    flush = 1'b1;
    @(negedge clk);
    check("flush0.valid", int'(valid), 0);
    check("flush0.cnt",   int'(pending_cnt), 0);
    flush = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      req   = tbl[i].req;
      ready = tbl[i].rdy;
      flush = tbl[i].fl;
      @(negedge clk);
      check($sformatf("vec%0d.valid", i), int'(valid), int'(tbl[i].v));
      check($sformatf("vec%0d.code", i),  int'(code), int'(tbl[i].c));
      check($sformatf("vec%0d.cnt", i),   int'(pending_cnt), int'(tbl[i].n));
    end
    flush = 1'b0;

    // Reset asserted while presenting: offer dropped at once, nothing accepted.
    req   = 16'h0010;
    ready = 1'b0;
    @(negedge clk);
    req = 16'h0000;
    @(negedge clk);
    check("midrst.pre_valid", int'(valid), 1);
    check("midrst.pre_code",  int'(code), 4);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.valid", int'(valid), 0);
    check("midrst.code",  int'(code), 0);
    check("midrst.cnt",   int'(pending_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    check("midrst.after_valid", int'(valid), 0);
    check("midrst.after_cnt",   int'(pending_cnt), 0);

    // Random traffic against the reference model.
    model_reset();
    for (int t = 0; t < 1500; t++) begin
      logic [15:0] r;
      logic        rd;
      logic        fl;
      r  = ($urandom_range(0, 2) == 0) ? 16'($urandom & $urandom & $urandom) : 16'h0000;
      rd = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 63) == 0);
      model_step(r, rd, fl);
      req   = r;
      ready = rd;
      flush = fl;
      @(negedge clk);
      check($sformatf("rnd%0d.valid", t), int'(valid), int'(m_pres));
      check($sformatf("rnd%0d.code", t),  int'(code), m_code);
      check($sformatf("rnd%0d.cnt", t),   int'(pending_cnt), model_cnt());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
